status_upload_ctrl: RTL



---
 rtl/status_upload_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/status_upload_ctrl.sv
// status_upload_ctrl: streams a header word plus a window of 64-bit status
// RAM words to a valid/ready TX sink. A credit counter (FIFO occupancy plus
// reads in flight) throttles reads so the 2-cycle RAM latency can never
// overflow the output FIFO under TX backpressure.
// Optional build macro STATUS_UPLOAD_CHKSUM_EN appends an XOR trailer word.
module status_upload_ctrl #(
    parameter int          RD_WORDS   = 128,
    parameter int          BASE_ADDR  = 0,
    parameter logic [15:0] HDR_MAGIC  = 16'h5A5A,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        upload_req,
    output logic [6:0]  status_ram_addr,
    output logic        status_ram_rd_en,
    input  logic [63:0] status_ram_data,
    input  logic        status_ram_data_vld,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int             PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]    DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  FULL_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  ONE_C    = CW'(1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [7:0]     LAST_IDX = 8'(RD_WORDS - 1);
    localparam logic [7:0]     WORDS_B  = 8'(RD_WORDS);
    localparam logic [6:0]     BASE_B   = 7'(BASE_ADDR);

`ifdef STATUS_UPLOAD_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, READ, DRAIN, TRL} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, READ, DRAIN} state_t;
`endif

    state_t          state, state_nxt;
    logic [64:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [7:0]      seq;
    logic [7:0]      idx;
    logic            fifo_wr, fifo_rd;
    logic [64:0]     fifo_din;
    logic [64:0]     head;
    logic            data_take;
    logic            rd_en;
    logic            credit_ok;
    logic [63:0]     hdr_word;
    logic            last_data;
`ifdef STATUS_UPLOAD_CHKSUM_EN
    logic [63:0]     chksum;
    logic            trl_done;
    logic            trl_wr;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign hdr_word  = {HDR_MAGIC, seq, WORDS_B, 32'h0};
    assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < DEPTH_C;
    // Returns arriving with nothing outstanding are leftovers from before a reset.
    assign data_take = status_ram_data_vld && (inflight != '0);
`ifdef STATUS_UPLOAD_CHKSUM_EN
    assign last_data = 1'b0;
`else
    // No reads are issued in DRAIN, so the return that empties the pipe is the final word.
    assign last_data = (state == DRAIN) && (inflight == ONE_C);
`endif

    assign head             = mem[rd_ptr];
    assign tx_valid         = (count != '0);
    assign tx_data          = tx_valid ? head[63:0] : '0;
    assign tx_last          = tx_valid && head[64];
    assign fifo_rd          = tx_valid && tx_ready;
    assign busy             = (state != IDLE);
    assign status_ram_rd_en = rd_en;
    assign status_ram_addr  = rd_en ? (BASE_B + idx[6:0]) : '0;

    // Next-state, read strobe and FIFO write selection.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
`ifdef STATUS_UPLOAD_CHKSUM_EN
        trl_wr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (upload_req) state_nxt = HDR;
            end
            HDR: begin
                fifo_wr   = 1'b1;
                fifo_din  = {1'b0, hdr_word};
                state_nxt = READ;
            end
            READ: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (idx == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
`ifdef STATUS_UPLOAD_CHKSUM_EN
                if (inflight == '0) state_nxt = TRL;
`else
                if ((inflight == '0) && (count == '0)) state_nxt = IDLE;
`endif
            end
`ifdef STATUS_UPLOAD_CHKSUM_EN
            TRL: begin
                if (!trl_done && (count != FULL_C)) begin
                    trl_wr   = 1'b1;
                    fifo_wr  = 1'b1;
                    fifo_din = {1'b1, chksum};
                end else if (trl_done && (count == '0)) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        if (data_take) begin
            fifo_wr  = 1'b1;
            fifo_din = {last_data, status_ram_data};
        end
    end

    // FIFO storage; pointers guard validity so entries need no reset.
    always_ff @(posedge sys_clk) begin
        if (fifo_wr) mem[wr_ptr] <= fifo_din;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Control state, read index, in-flight credit, sequence and drop counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= '0;
            idx      <= '0;
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            case ({rd_en, data_take})
                2'b10:   inflight <= inflight + ONE_C;
                2'b01:   inflight <= inflight - ONE_C;
                default: inflight <= inflight;
            endcase
            if (state == HDR)  idx <= '0;
            else if (rd_en)    idx <= idx + 8'd1;
            if (fifo_rd && head[64]) seq <= seq + 8'd1;
            if (upload_req && (state != IDLE) && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef STATUS_UPLOAD_CHKSUM_EN
    // Running XOR over header and data words as they enter the FIFO.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            chksum   <= '0;
            trl_done <= 1'b0;
        end else begin
            if (state == HDR)   chksum <= hdr_word;
            else if (data_take) chksum <= chksum ^ status_ram_data;
            if (state == HDR)   trl_done <= 1'b0;
            else if (trl_wr)    trl_done <= 1'b1;
        end
    end
`endif

    // Credit accounting must make a write into a full FIFO impossible.
    always_ff @(posedge sys_clk) begin
        if (!rst) assert (!(fifo_wr && (count == FULL_C)));
    end

endmodule
